// File: rtl/thirty_two_bit_alu_core.sv
// ============================================================================
// Module   : thirty_two_bit_alu_core
// Brief    : Registered 32-bit ALU (clear/add/sub/shl/shr/and/or/xor) with a
//            fixed one-cycle latency. Optional flags enabled by ALU_FLAGS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module thirty_two_bit_alu_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  inp,
  input  logic        in_valid,
  output logic [31:0] out,
  output logic        out_valid
`ifdef ALU_FLAGS_EN
  ,
  output logic        carry,
  output logic        zero,
  output logic        overflow
`endif
);

  localparam logic [2:0] c_OP_CLR = 3'b000;
  localparam logic [2:0] c_OP_ADD = 3'b001;
  localparam logic [2:0] c_OP_SUB = 3'b010;
  localparam logic [2:0] c_OP_SHL = 3'b011;
  localparam logic [2:0] c_OP_SHR = 3'b100;
  localparam logic [2:0] c_OP_AND = 3'b101;
  localparam logic [2:0] c_OP_OR  = 3'b110;
  localparam logic [2:0] c_OP_XOR = 3'b111;

  // 33-bit forms: bit 32 is carry-out for add and borrow for sub
  logic [32:0] w_sum;
  logic [32:0] w_diff;
  logic [31:0] result_d;
  logic [31:0] out_q;
  logic        out_valid_q;

  assign w_sum  = {1'b0, a} + {1'b0, b};
  assign w_diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result_d = 32'd0;
    case (inp)
      c_OP_CLR: result_d = 32'd0;
      c_OP_ADD: result_d = w_sum[31:0];
      c_OP_SUB: result_d = w_diff[31:0];
      c_OP_SHL: result_d = {a[30:0], 1'b0};
      c_OP_SHR: result_d = {1'b0, a[31:1]};
      c_OP_AND: result_d = a & b;
      c_OP_OR:  result_d = a | b;
      c_OP_XOR: result_d = a ^ b;
      default:  result_d = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= 32'd0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        out_q <= result_d;
      end
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

`ifdef ALU_FLAGS_EN
  logic carry_d;
  logic overflow_d;
  logic carry_q;
  logic zero_q;
  logic overflow_q;

  always_comb begin
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    case (inp)
      c_OP_ADD: begin
        carry_d    = w_sum[32];
        overflow_d = (a[31] == b[31]) && (w_sum[31] != a[31]);
      end
      c_OP_SUB: begin
        carry_d    = w_diff[32];
        overflow_d = (a[31] != b[31]) && (w_diff[31] != a[31]);
      end
      c_OP_SHL: carry_d = a[31];
      c_OP_SHR: carry_d = a[0];
      default: begin
        carry_d    = 1'b0;
        overflow_d = 1'b0;
      end
    endcase
  end

  // Flags travel with out: they hold whenever out holds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else if (in_valid) begin
      carry_q    <= carry_d;
      zero_q     <= (result_d == 32'd0);
      overflow_q <= overflow_d;
    end
  end

  assign carry    = carry_q;
  assign zero     = zero_q;
  assign overflow = overflow_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_thirty_two_bit_alu_core.sv
// ============================================================================
// Module   : tb_thirty_two_bit_alu_core
// Brief    : Directed scoreboard bench for thirty_two_bit_alu_core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_thirty_two_bit_alu_core;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  inp;
  logic        in_valid;
  logic [31:0] out;
  logic        out_valid;
`ifdef ALU_FLAGS_EN
  logic        carry;
  logic        zero;
  logic        overflow;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic [31:0] res;
    logic        c;
    logic        z;
    logic        v;
  } exp_t;

  exp_t sb[$];

  thirty_two_bit_alu_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a         (a),
    .b         (b),
    .inp       (inp),
    .in_valid  (in_valid),
    .out       (out),
    .out_valid (out_valid)
`ifdef ALU_FLAGS_EN
    ,
    .carry     (carry),
    .zero      (zero),
    .overflow  (overflow)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_flags(input string tag, input logic c, input logic z, input logic v);
`ifdef ALU_FLAGS_EN
    chk({tag, ".carry"},    {31'd0, carry},    {31'd0, c});
    chk({tag, ".zero"},     {31'd0, zero},     {31'd0, z});
    chk({tag, ".overflow"}, {31'd0, overflow}, {31'd0, v});
`endif
  endtask

  // Drive one valid op, push its expectation, then compare after the edge
  task automatic op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                    input logic [2:0] code, input logic [31:0] res,
                    input logic c, input logic z, input logic v);
    exp_t e;
    @(negedge clk);
    a = av; b = bv; inp = code; in_valid = 1'b1;
    e.tag = tag; e.res = res; e.c = c; e.z = z; e.v = v;
    sb.push_back(e);
    @(posedge clk);
    #1;
    n_checks++;
    assert (sb.size() > 0)
    else begin
      n_fail++;
      $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, ".out"}, out, e.res);
      chk({e.tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
      chk_flags(e.tag, e.c, e.z, e.v);
    end
  endtask

  task automatic idle(input string tag, input logic [31:0] res,
                      input logic c, input logic z, input logic v);
    @(negedge clk);
    in_valid = 1'b0;
    a = 32'hDEAD_BEEF; b = 32'h1234_5678; inp = 3'b001;
    @(posedge clk);
    #1;
    chk({tag, ".out"}, out, res);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
    chk_flags(tag, c, z, v);
  endtask

  initial begin
    rst_n = 1'b0; a = 32'd0; b = 32'd0; inp = 3'b000; in_valid = 1'b0;
    #1;
    chk("reset.out", out, 32'd0);
    chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
    chk_flags("reset", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Arithmetic
    op("add",      32'd21,         32'd10, 3'b001, 32'd31,         1'b0, 1'b0, 1'b0);
    op("sub",      32'd54,         32'd9,  3'b010, 32'd45,         1'b0, 1'b0, 1'b0);
    op("sub_brw",  32'd0,          32'd1,  3'b010, 32'hFFFF_FFFF,  1'b1, 1'b0, 1'b0);
    op("add_wrap", 32'hFFFF_FFFF,  32'd1,  3'b001, 32'd0,          1'b1, 1'b1, 1'b0);
    op("add_ovf",  32'h7FFF_FFFF,  32'd1,  3'b001, 32'h8000_0000,  1'b0, 1'b0, 1'b1);
    op("sub_ovf",  32'h8000_0000,  32'd1,  3'b010, 32'h7FFF_FFFF,  1'b0, 1'b0, 1'b1);
    // Shifts
    op("shl",      32'd10,         32'hFFFF_FFFF, 3'b011, 32'd20,  1'b0, 1'b0, 1'b0);
    op("shr",      32'd15,         32'hFFFF_FFFF, 3'b100, 32'd7,   1'b1, 1'b0, 1'b0);
    op("shl_msb",  32'h8000_0000,  32'd0,  3'b011, 32'd0,          1'b1, 1'b1, 1'b0);
    op("shr_msb",  32'h8000_0000,  32'd0,  3'b100, 32'h4000_0000,  1'b0, 1'b0, 1'b0);
    // Logic and clear
    op("clear",    32'h1234_5678,  32'h9ABC_DEF0, 3'b000, 32'd0,   1'b0, 1'b1, 1'b0);
    op("and",      32'd1,          32'd0,  3'b101, 32'd0,          1'b0, 1'b1, 1'b0);
    op("or",       32'd0,          32'd1,  3'b110, 32'd1,          1'b0, 1'b0, 1'b0);
    op("xor",      32'd1,          32'd1,  3'b111, 32'd0,          1'b0, 1'b1, 1'b0);
    op("and_pat",  32'hF0F0_FF00,  32'hFF00_F0F0, 3'b101, 32'hF000_F000, 1'b0, 1'b0, 1'b0);
    op("or_pat",   32'hF0F0_0000,  32'h0F00_00FF, 3'b110, 32'hFFF0_00FF, 1'b0, 1'b0, 1'b0);
    op("xor_pat",  32'hAAAA_5555,  32'hFFFF_0000, 3'b111, 32'h5555_5555, 1'b0, 1'b0, 1'b0);

    // Hold: out and flags keep the last accepted result
    op("hold_add", 32'd21, 32'd10, 3'b001, 32'd31, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle("hold", 32'd31, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-stream, with operands presented during reset
    op("pre_rst", 32'hFFFF_FFFF, 32'd1, 3'b001, 32'd0, 1'b1, 1'b1, 1'b0);
    op("pre_rst2", 32'd21, 32'd10, 3'b001, 32'd31, 1'b0, 1'b0, 1'b0);
    a = 32'd5; b = 32'd7; inp = 3'b001; in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst.out", out, 32'd0);
    chk("async_rst.out_valid", {31'd0, out_valid}, 32'd0);
    chk_flags("async_rst", 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("in_rst.out", out, 32'd0);
    chk("in_rst.out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    idle("post_rst", 32'd0, 1'b0, 1'b0, 1'b0);
    op("first_acc", 32'd3, 32'd4, 3'b001, 32'd7, 1'b0, 1'b0, 1'b0);

    n_checks++;
    assert (sb.size() == 0)
    else begin
      n_fail++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
